// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module : load_store_unit_pkg
// Brief  : Opcode/funct3 constants, FSM encoding and access-check helpers
//          shared by the load/store unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  // Size comes from funct3[1:0]; byte accesses can never be misaligned.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_data_align.sv
// ============================================================================
// Module : lsu_data_align
// Brief  : Combinational lane logic: store strobes/replicated data and load
//          shift with sign or zero extension.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [15:0] w_shifted;

  // Only the low halfword of the shifted word is ever consumed.
  assign w_shifted = 16'(mem_rdata >> {addr_lo, 3'b000});

  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    load_data = mem_rdata;
    case (funct3)
      F3_B:    load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    load_data = {{16{w_shifted[15]}}, w_shifted};
      F3_BU:   load_data = {24'd0, w_shifted[7:0]};
      F3_HU:   load_data = {16'd0, w_shifted};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : LOAD/STORE memory-side unit with alignment/legality checks and a
//          valid/ready + rvalid data-memory port. Optional LSU_TIMEOUT_EN
//          adds a wait counter that raises bus_error.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal,
  output logic        bus_error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state;
  lsu_state_t  w_state_nxt;

  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [31:0] r_load_data;
  logic        r_misaligned;
  logic        r_illegal;
  logic        r_bus_error;

  logic        w_is_load_op;
  logic        w_is_store_op;
  logic        w_accept;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_capture;
  logic        w_set_bus_error;
  logic        w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_load_ext;

  assign w_is_load_op  = (opcode == OP_LOAD);
  assign w_is_store_op = (opcode == OP_STORE);
  assign w_accept      = req_valid && (r_state == ST_IDLE) && (w_is_load_op || w_is_store_op);

  // An illegal funct3 suppresses the alignment fault.
  assign w_illegal    = !f3_legal(w_is_store_op, funct3);
  assign w_misaligned = !w_illegal && addr_misaligned(funct3, address[1:0]);

  lsu_data_align u_align (
    .funct3     (r_funct3),
    .addr_lo    (r_addr[1:0]),
    .store_data (r_sdata),
    .mem_rdata  (mem_rdata),
    .wstrb      (w_wstrb),
    .wdata      (w_wdata),
    .load_data  (w_load_ext)
  );

`ifdef LSU_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 8'd0;
    end else if (w_accept) begin
      r_wait_cnt <= 8'd0;
    end else if ((r_state == ST_REQ) || (r_state == ST_WAIT_R)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Fires in the cycle whose increment would bring the count to the limit.
  assign w_timeout = ((r_state == ST_REQ) || (r_state == ST_WAIT_R)) &&
                     (({1'b0, r_wait_cnt} + 9'd1) >= 9'(TIMEOUT_CYCLES));
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_capture       = 1'b0;
    w_set_bus_error = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_illegal || w_misaligned) ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          if (r_is_store) begin
            w_state_nxt = ST_RESP;
          end else if (mem_rvalid) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT_R;
          end
        end else if (w_timeout) begin
          w_set_bus_error = 1'b1;
          w_state_nxt     = ST_RESP;
        end
      end
      ST_WAIT_R: begin
        if (mem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_timeout) begin
          w_set_bus_error = 1'b1;
          w_state_nxt     = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= 32'd0;
      r_sdata      <= 32'd0;
      r_load_data  <= 32'd0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_is_store   <= w_is_store_op;
        r_funct3     <= funct3;
        r_addr       <= address;
        r_sdata      <= store_data;
        r_misaligned <= w_misaligned;
        r_illegal    <= w_illegal;
        r_load_data  <= 32'd0;
        r_bus_error  <= 1'b0;
      end
      if (w_capture) begin
        r_load_data <= w_load_ext;
      end
      if (w_set_bus_error) begin
        r_bus_error <= 1'b1;
      end
    end
  end

  // Outputs decode straight from the asynchronously reset state register.
  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign load_data  = (resp_valid && !r_is_store) ? r_load_data : 32'd0;
  assign misaligned = resp_valid && r_misaligned;
  assign illegal    = resp_valid && r_illegal;
  assign bus_error  = resp_valid && r_bus_error;

  assign mem_valid  = (r_state == ST_REQ);
  assign mem_write  = mem_valid && r_is_store;
  assign mem_addr   = mem_valid ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_wstrb  = mem_write ? w_wstrb : 4'b0000;
  assign mem_wdata  = mem_write ? w_wdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed self-checking bench for load_store_unit with a reference
//          model of the access rules and a per-cycle compare process.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;
  logic        bus_error;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_vec  = 0;
  int n_err  = 0;
  int n_resp = 0;

  logic        m_mem, m_write, m_mis, m_ill, m_bus;
  logic [31:0] m_addr, m_wdata, m_load;
  logic [3:0]  m_wstrb;

  int          obs_lat;
  logic [31:0] obs_load;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_wstrb;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .address    (address),
    .store_data (store_data),
    .resp_valid (resp_valid),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal),
    .bus_error  (bus_error),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference rules: size in bytes, byte offset, lane mask and extension by arithmetic.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input bit tmo);
    int     sz, off;
    longint v;
    off     = int'(a % 4);
    m_ill   = st ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz      = 1 << f3[1:0];
    m_mis   = !m_ill && ((off % sz) != 0);
    m_mem   = !m_ill && !m_mis;
    m_write = st;
    m_addr  = a - 32'(off);
    m_wstrb = 4'd0;
    m_wdata = 32'd0;
    m_load  = 32'd0;
    m_bus   = tmo && m_mem;
    if (st && m_mem) begin
      m_wstrb = 4'(((1 << sz) - 1) << off);
      case (sz)
        1:       m_wdata = sd[7:0] * 32'h01010101;
        2:       m_wdata = sd[15:0] * 32'h00010001;
        default: m_wdata = sd;
      endcase
    end
    if (!st && m_mem && !tmo) begin
      if (sz == 4) begin
        m_load = rd;
      end else begin
        v = longint'(rd >> (8 * off));
        v = v % (longint'(1) << (8 * sz));
        if (!f3[2] && (v >= (longint'(1) << (8 * sz - 1)))) v = v - (longint'(1) << (8 * sz));
        m_load = 32'(v);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_valid) begin
        chk("mem_valid_allowed", 32'(m_mem), 32'd1);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_write", 32'(mem_write), 32'(m_write));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
        if (m_write) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (resp_valid) begin
        n_resp++;
        chk("load_data", load_data, m_load);
        chk("misaligned", 32'(misaligned), 32'(m_mis));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("bus_error", 32'(bus_error), 32'(m_bus));
      end
    end
  end

  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int rdy, input int rv,
                           input logic [31:0] rd, input bit tmo);
    int vcnt, rvc, exp_lat;
    bit done;
    model(st, f3, a, sd, rd, tmo);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    opcode     = st ? 7'b0100011 : 7'b0000011;
    funct3     = f3;
    address    = a;
    store_data = sd;
    vcnt = 0; rvc = 0; done = 1'b0;
    obs_lat = -1; obs_load = 32'hxxxxxxxx; obs_wdata = 32'd0; obs_wstrb = 4'd0;
    for (int k = 1; k <= 300 && !done; k++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      opcode     = 7'd0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h5A5A5A5A;
      if (resp_valid) begin
        done     = 1'b1;
        obs_lat  = k;
        obs_load = load_data;
      end else if (mem_valid) begin
        if (vcnt >= rdy) begin
          mem_ready = 1'b1;
          obs_wdata = mem_wdata;
          obs_wstrb = mem_wstrb;
          if (!st) begin
            if (rv == 0) begin
              mem_rvalid = 1'b1;
              mem_rdata  = rd;
            end else begin
              rvc = rv;
            end
          end
        end
        vcnt++;
      end else if (rvc > 0) begin
        rvc--;
        if (rvc == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd;
        end
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_wait: got no resp_valid expected one within 300 cycles");
    end else begin
      if (tmo)         exp_lat = TO + 1;
      else if (!m_mem) exp_lat = 1;
      else if (st)     exp_lat = rdy + 2;
      else             exp_lat = rdy + 2 + rv;
      chk("latency", 32'(obs_lat), 32'(exp_lat));
    end
    @(negedge clk);
    chk("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    reset_n = 1'b1;

    // Stores
    do_access(1'b1, 3'b010, 32'h00001000, 32'hDEADBEEF, 0, 0, 32'd0, 1'b0);
    chk("sw_lat_lit", 32'(obs_lat), 32'd2);
    chk("sw_wdata_lit", obs_wdata, 32'hDEADBEEF);
    do_access(1'b1, 3'b000, 32'h00002003, 32'h000000A5, 3, 0, 32'd0, 1'b0);
    chk("sb_lat_lit", 32'(obs_lat), 32'd5);
    chk("sb_wstrb_lit", 32'(obs_wstrb), 32'h8);
    chk("sb_wdata_lit", obs_wdata, 32'hA5A5A5A5);
    do_access(1'b1, 3'b001, 32'h00002002, 32'h1234ABCD, 1, 0, 32'd0, 1'b0);
    chk("sh_wstrb_lit", 32'(obs_wstrb), 32'hC);
    do_access(1'b1, 3'b000, 32'h00002001, 32'hFFFFFF3C, 0, 0, 32'd0, 1'b0);

    // Loads
    do_access(1'b0, 3'b000, 32'h00003002, 32'd0, 0, 2, 32'h12803456, 1'b0);
    chk("lb_lit", obs_load, 32'hFFFFFF80);
    do_access(1'b0, 3'b100, 32'h00003002, 32'd0, 0, 2, 32'h12803456, 1'b0);
    chk("lbu_lit", obs_load, 32'h00000080);
    do_access(1'b0, 3'b001, 32'h00003002, 32'd0, 1, 0, 32'hBEEF0000, 1'b0);
    chk("lh_lit", obs_load, 32'hFFFFBEEF);
    do_access(1'b0, 3'b101, 32'h00003000, 32'd0, 0, 1, 32'h0000BEEF, 1'b0);
    do_access(1'b0, 3'b010, 32'h00004000, 32'd0, 2, 0, 32'hCAFEF00D, 1'b0);
    chk("lw_lit", obs_load, 32'hCAFEF00D);
    do_access(1'b0, 3'b000, 32'h00003001, 32'd0, 0, 0, 32'h00007F00, 1'b0);

    // Faulting accesses
    do_access(1'b0, 3'b010, 32'h00004002, 32'd0, 0, 0, 32'd0, 1'b0);
    chk("lw_mis_lat_lit", 32'(obs_lat), 32'd1);
    do_access(1'b0, 3'b001, 32'h00004001, 32'd0, 0, 0, 32'd0, 1'b0);
    do_access(1'b1, 3'b001, 32'h00002001, 32'h1234, 0, 0, 32'd0, 1'b0);
    do_access(1'b0, 3'b011, 32'h00004000, 32'd0, 0, 0, 32'd0, 1'b0);
    do_access(1'b1, 3'b100, 32'h00004000, 32'd0, 0, 0, 32'd0, 1'b0);
    do_access(1'b0, 3'b110, 32'h00004003, 32'd0, 0, 0, 32'd0, 1'b0);

    // Unrelated opcode is ignored
    m_mem = 1'b0;
    start = n_resp;
    @(negedge clk);
    req_valid = 1'b1; opcode = 7'b0110011; funct3 = 3'b010; address = 32'h4000;
    @(negedge clk);
    req_valid = 1'b0; opcode = 7'd0;
    chk("other_op_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("other_op_no_resp", 32'(n_resp - start), 32'd0);

    // Reset while in REQ: mem_valid must drop before any clock edge
    model(1'b0, 3'b010, 32'h00005000, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; opcode = 7'b0000011; funct3 = 3'b010; address = 32'h5000;
    @(negedge clk);
    req_valid = 1'b0; opcode = 7'd0;
    chk("req_mem_valid", 32'(mem_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_mem_valid_drop", 32'(mem_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset while in WAIT_R, then a stale rvalid
    model(1'b0, 3'b000, 32'h00003002, 32'd0, 32'h12803456, 1'b0);
    start = n_resp;
    @(negedge clk);
    req_valid = 1'b1; opcode = 7'b0000011; funct3 = 3'b000; address = 32'h3002;
    @(negedge clk);
    req_valid = 1'b0; opcode = 7'd0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("wait_r_ready_low", 32'(req_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1 chk("rst_wait_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_wait_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12803456;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stale_rvalid_no_resp", 32'(n_resp - start), 32'd0);
    do_access(1'b0, 3'b010, 32'h00004004, 32'd0, 0, 1, 32'h0BADF00D, 1'b0);
    chk("lw_after_reset_lit", obs_load, 32'h0BADF00D);

`ifdef LSU_TIMEOUT_EN
    do_access(1'b0, 3'b010, 32'h00006000, 32'd0, 1000, 0, 32'hFFFFFFFF, 1'b1);
    chk("timeout_load_lit", obs_load, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-side consumer of the effective addresses produced for LOAD/STORE instructions in the phoeniX core.
- Accepts one access per request: opcode, funct3, computed address, store data.
- Checks alignment and funct3 legality.
- Drives a word-addressed data-memory port using a valid/ready request handshake and an rvalid response.
- Returns sign- or zero-extended load data, or store completion, to the pipeline.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent waiting for mem_ready or mem_rvalid before bus_error is raised. Used only with LSU_TIMEOUT_EN.

Ports:
clk  input  1  core clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  pipeline presents an access
req_ready  output  1  unit idle; request accepted when req_valid && req_ready
opcode  input  7  LOAD 7'b0000011 or STORE 7'b0100011; any other value is ignored
funct3  input  3  width and signedness field (LB/LH/LW/LBU/LHU, SB/SH/SW)
address  input  32  byte effective address
store_data  input  32  rs2 value; LSBs used for SB/SH
resp_valid  output  1  one-cycle completion pulse
load_data  output  32  extended load result; valid with resp_valid on a load, 0 otherwise
misaligned  output  1  valid with resp_valid; access not naturally aligned
illegal  output  1  valid with resp_valid; funct3 reserved for the opcode
bus_error  output  1  valid with resp_valid; memory timeout (LSU_TIMEOUT_EN only)
mem_valid  output  1  memory request valid
mem_ready  input  1  memory accepts request
mem_write  output  1  1 = store
mem_addr  output  32  {address[31:2], 2'b00}
mem_wstrb  output  4  byte lane enables; 0 on loads
mem_wdata  output  32  lane-replicated store data
mem_rvalid  input  1  load data valid
mem_rdata  input  32  word read data

Behaviour:
- Reset: FSM enters IDLE. All outputs are 0 except req_ready, which is 1. Registered request fields are cleared.
- Reset asserted mid-access: immediate return to IDLE, mem_valid drops asynchronously, no resp_valid. An rvalid arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid with LOAD or STORE opcode, register opcode, funct3, address and store_data.
  - If misaligned or illegal, go to RESP; no memory access is made.
  - Otherwise go to REQ.
  - Any other opcode leaves the unit in IDLE with no effect.
- REQ:
  - mem_valid=1; all mem_* outputs are held stable until mem_ready.
  - Store with mem_ready: go to RESP.
  - Load with mem_ready: go to WAIT_R.
  - Load where mem_ready and mem_rvalid arrive in the same cycle: capture data, go to RESP.
- WAIT_R: on mem_rvalid, capture data, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready returns to 1 in the following cycle.
- Latency:
  - Zero-wait store: accept at T, REQ at T+1, resp_valid at T+2.
  - Zero-wait load: same timing when rvalid coincides with ready.
- Alignment:
  - Halfword access is misaligned when address[0]=1.
  - Word access is misaligned when address[1:0]!=0.
  - Byte accesses are never misaligned.
- Legal funct3:
  - LOAD: 000, 001, 010, 100, 101.
  - STORE: 000, 001, 010.
  - Any other value sets illegal=1.
  - If both illegal and misaligned apply, illegal wins and misaligned=0.
- Store strobes:
  - SB: mem_wstrb = 4'b0001 << address[1:0].
  - SH: mem_wstrb = 4'b0011 << address[1:0].
  - SW: mem_wstrb = 4'b1111.
- Store data:
  - SB: byte replicated into all four lanes.
  - SH: halfword replicated into both lanes.
  - SW: word passed unchanged.
- Load extraction:
  - Shift mem_rdata right by 8*address[1:0].
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: unchanged.
- mem_rvalid outside REQ/WAIT_R is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - 8-bit wait counter is cleared on entry to REQ and increments each cycle spent in REQ or WAIT_R.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP with bus_error=1, load_data=0 and mem_valid dropped.
- Undefined: no counter; the unit waits indefinitely; bus_error is tied to 0.

Decomposition:
- Shared package holds:
  - LOAD/STORE opcode constants.
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state encoding: 2-bit IDLE=0, REQ=1, WAIT_R=2, RESP=3.
- One natural sub-module: lsu_data_align. Purely combinational:
  - store-side wstrb and wdata generation;
  - load-side shift and sign/zero extension.
- The FSM remains in load_store_unit.

Test Plan:
- SW addr 0x1000, data 0xDEADBEEF, mem_ready held high → mem_addr=0x1000, wstrb=1111, wdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- SB addr 0x2003, data 0x000000A5 → wstrb=1000, wdata=0xA5A5A5A5. With mem_ready delayed 3 cycles, mem_* are held stable and resp_valid arrives 1 cycle after ready.
- LB addr 0x3002, rdata 0x12803456, rvalid 2 cycles after ready → load_data=0xFFFFFF80. Same access as LBU → 0x00000080.
- LW addr 0x4002 → misaligned=1, mem_valid never asserted, resp_valid 1 cycle after accept. LOAD funct3=011 → illegal=1.
- Reset_n pulled low while in WAIT_R → mem_valid=0 immediately, no resp_valid. A late rvalid after reset release is ignored; the next LW then completes normally.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mem_ready held low → bus_error=1 with resp_valid, load_data=0, unit back in IDLE.
